tx_turn_arbiter: RTL and testbench

TX_TURN_ARBITER -- requirements
Module: tx_turn_arbiter

---
 rtl/tx_turn_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_tx_turn_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_turn_arbiter.sv
// rtl/tx_turn_arbiter.sv - round-robin turn arbiter sharing one TX TLP interface among N engines
module tx_turn_arbiter #(
   parameter int N_ENG       = 3,
   parameter int TURN_WINDOW = 4,
   parameter int BUSY_LIMIT  = 1024,
   localparam int IDX_W      = (N_ENG > 1) ? $clog2(N_ENG) : 1
) (
   input  logic                  trn_clk,
   input  logic                  reset,
   input  logic [N_ENG-1:0]      eng_enable,
   output logic [N_ENG-1:0]      my_turn,
   input  logic [N_ENG-1:0]      driving_interface,
   input  logic [64*N_ENG-1:0]   eng_trn_td,
   input  logic [8*N_ENG-1:0]    eng_trn_trem_n,
   input  logic [N_ENG-1:0]      eng_trn_tsof_n,
   input  logic [N_ENG-1:0]      eng_trn_teof_n,
   input  logic [N_ENG-1:0]      eng_trn_tsrc_rdy_n,
   input  logic [N_ENG-1:0]      eng_cfg_interrupt_n,
   output logic [63:0]           trn_td,
   output logic [7:0]            trn_trem_n,
   output logic                  trn_tsof_n,
   output logic                  trn_teof_n,
   output logic                  trn_tsrc_rdy_n,
   output logic                  cfg_interrupt_n,
   output logic [IDX_W-1:0]      cur_idx,
   output logic                  busy_timeout,
   output logic [IDX_W-1:0]      timeout_idx,
   output logic                  proto_err
);

   localparam int WIN_W  = $clog2(TURN_WINDOW + 1);
   localparam int BUSY_W = $clog2(BUSY_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, GRANT, GUARD, BUSY} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  cur_idx_q, cur_idx_d;
   logic [N_ENG-1:0]  my_turn_q, my_turn_d;
   logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
   logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
   logic              busy_timeout_q, busy_timeout_d;
   logic [IDX_W-1:0]  timeout_idx_q, timeout_idx_d;
   logic              proto_err_q, proto_err_d;

   logic [N_ENG-1:0]  cur_mask;
   logic [IDX_W-1:0]  first_idx;
   logic [IDX_W-1:0]  idx_inc;
   logic              drive_cur;
   logic              en_cur;
   logic              foreign_drive;
   logic              found;
   int                cand;

   function automatic logic [N_ENG-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [N_ENG-1:0] v;
      v = '0;
      for (int i = 0; i < N_ENG; i++) begin
         if (IDX_W'(i) == idx) v[i] = 1'b1;
      end
      return v;
   endfunction

   // Search upward from the current index (inclusive) so the turn order stays fair.
   always_comb begin
      first_idx = cur_idx_q;
      found     = 1'b0;
      cand      = 0;
      for (int k = 0; k < N_ENG; k++) begin
         cand = (int'(cur_idx_q) + k) % N_ENG;
         if (!found && eng_enable[cand]) begin
            found     = 1'b1;
            first_idx = IDX_W'(cand);
         end
      end
   end

   always_comb begin
      cur_mask      = onehot(cur_idx_q);
      idx_inc       = (cur_idx_q == IDX_W'(N_ENG - 1)) ? '0 : cur_idx_q + 1'b1;
      drive_cur     = |(driving_interface & cur_mask);
      en_cur        = |(eng_enable & cur_mask);
      foreign_drive = (state_q == IDLE) ? |driving_interface
                                        : |(driving_interface & ~cur_mask);
   end

   always_comb begin
      state_d        = state_q;
      cur_idx_d      = cur_idx_q;
      my_turn_d      = my_turn_q;
      win_cnt_d      = win_cnt_q;
      busy_cnt_d     = busy_cnt_q;
      busy_timeout_d = busy_timeout_q;
      timeout_idx_d  = timeout_idx_q;
      proto_err_d    = proto_err_q | foreign_drive;
      case (state_q)
         IDLE: begin
            my_turn_d = '0;
            if (|eng_enable) begin
               state_d   = GRANT;
               cur_idx_d = first_idx;
               my_turn_d = onehot(first_idx);
               win_cnt_d = WIN_W'(1);
            end
         end
         GRANT: begin
            // Drive is checked first so it wins over a window expiring in the same cycle.
            if (drive_cur) begin
               state_d    = BUSY;
               my_turn_d  = '0;
               busy_cnt_d = '0;
            end else if (win_cnt_q == WIN_W'(TURN_WINDOW) || !en_cur) begin
               state_d   = GUARD;
               my_turn_d = '0;
            end else begin
               win_cnt_d = win_cnt_q + 1'b1;
            end
         end
         GUARD: begin
            my_turn_d = '0;
            if (drive_cur) begin
               state_d    = BUSY;
               busy_cnt_d = '0;
            end else begin
               state_d   = IDLE;
               cur_idx_d = idx_inc;
            end
         end
         BUSY: begin
            my_turn_d = '0;
            if (!drive_cur) begin
               state_d   = IDLE;
               cur_idx_d = idx_inc;
            end
            if (busy_cnt_q != BUSY_W'(BUSY_LIMIT)) begin
               busy_cnt_d = busy_cnt_q + 1'b1;
               if (busy_cnt_q == BUSY_W'(BUSY_LIMIT - 1) && !busy_timeout_q) begin
                  busy_timeout_d = 1'b1;
                  timeout_idx_d  = cur_idx_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge trn_clk) begin
      if (reset) begin
         state_q        <= IDLE;
         cur_idx_q      <= '0;
         my_turn_q      <= '0;
         win_cnt_q      <= '0;
         busy_cnt_q     <= '0;
         busy_timeout_q <= 1'b0;
         timeout_idx_q  <= '0;
         proto_err_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         cur_idx_q      <= cur_idx_d;
         my_turn_q      <= my_turn_d;
         win_cnt_q      <= win_cnt_d;
         busy_cnt_q     <= busy_cnt_d;
         busy_timeout_q <= busy_timeout_d;
         timeout_idx_q  <= timeout_idx_d;
         proto_err_q    <= proto_err_d;
      end
   end

   // The mux follows only cur_idx, so a foreign driver can never steer the interface.
   always_comb begin
      trn_td          = '0;
      trn_trem_n      = 8'hFF;
      trn_tsof_n      = 1'b1;
      trn_teof_n      = 1'b1;
      trn_tsrc_rdy_n  = 1'b1;
      cfg_interrupt_n = 1'b1;
      if (state_q != IDLE) begin
         for (int i = 0; i < N_ENG; i++) begin
            if (IDX_W'(i) == cur_idx_q) begin
               trn_td          = eng_trn_td[64*i +: 64];
               trn_trem_n      = eng_trn_trem_n[8*i +: 8];
               trn_tsof_n      = eng_trn_tsof_n[i];
               trn_teof_n      = eng_trn_teof_n[i];
               trn_tsrc_rdy_n  = eng_trn_tsrc_rdy_n[i];
               cfg_interrupt_n = eng_cfg_interrupt_n[i];
            end
         end
      end
   end

   assign my_turn      = my_turn_q;
   assign cur_idx      = cur_idx_q;
   assign busy_timeout = busy_timeout_q;
   assign timeout_idx  = timeout_idx_q;
   assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_tx_turn_arbiter.sv
// tb/tb_tx_turn_arbiter.sv - scoreboard bench for tx_turn_arbiter
module tb_tx_turn_arbiter;

   logic          clk;
   logic          reset;
   logic [2:0]    eng_enable;
   logic [2:0]    my_turn;
   logic [2:0]    driving_interface;
   logic [191:0]  eng_trn_td;
   logic [23:0]   eng_trn_trem_n;
   logic [2:0]    eng_trn_tsof_n;
   logic [2:0]    eng_trn_teof_n;
   logic [2:0]    eng_trn_tsrc_rdy_n;
   logic [2:0]    eng_cfg_interrupt_n;
   logic [63:0]   trn_td;
   logic [7:0]    trn_trem_n;
   logic          trn_tsof_n;
   logic          trn_teof_n;
   logic          trn_tsrc_rdy_n;
   logic          cfg_interrupt_n;
   logic [1:0]    cur_idx;
   logic          busy_timeout;
   logic [1:0]    timeout_idx;
   logic          proto_err;

   tx_turn_arbiter #(.N_ENG(3), .TURN_WINDOW(4), .BUSY_LIMIT(16)) dut (
      .trn_clk(clk),
      .reset(reset),
      .eng_enable(eng_enable),
      .my_turn(my_turn),
      .driving_interface(driving_interface),
      .eng_trn_td(eng_trn_td),
      .eng_trn_trem_n(eng_trn_trem_n),
      .eng_trn_tsof_n(eng_trn_tsof_n),
      .eng_trn_teof_n(eng_trn_teof_n),
      .eng_trn_tsrc_rdy_n(eng_trn_tsrc_rdy_n),
      .eng_cfg_interrupt_n(eng_cfg_interrupt_n),
      .trn_td(trn_td),
      .trn_trem_n(trn_trem_n),
      .trn_tsof_n(trn_tsof_n),
      .trn_teof_n(trn_teof_n),
      .trn_tsrc_rdy_n(trn_tsrc_rdy_n),
      .cfg_interrupt_n(cfg_interrupt_n),
      .cur_idx(cur_idx),
      .busy_timeout(busy_timeout),
      .timeout_idx(timeout_idx),
      .proto_err(proto_err)
   );

   typedef struct {
      int         cyc;
      string      name;
      logic [2:0] turn;
      logic [1:0] idx;
      int         sel;
      logic       bt;
      logic [1:0] tidx;
      logic       pe;
   } exp_t;

   exp_t       sb[$];
   exp_t       m_e;
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;
   logic       g_rst;
   logic       g_bt;
   logic [1:0] g_tidx;
   logic       g_pe;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [75:0] exp_out(input int sel);
      if (sel < 0) return {64'h0, 8'hFF, 4'hF};
      return {eng_trn_td[sel*64 +: 64], eng_trn_trem_n[sel*8 +: 8], eng_trn_tsof_n[sel],
              eng_trn_teof_n[sel], eng_trn_tsrc_rdy_n[sel], eng_cfg_interrupt_n[sel]};
   endfunction

   task automatic chk(input string tag, input string fld, input logic [75:0] act, input logic [75:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s.%s cyc=%0d got=%0h want=%0h", tag, fld, cyc, act, want);
      end
   endtask

   // Monitor: pops every expectation due this cycle and compares against the DUT.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         m_e = sb.pop_front();
         chk(m_e.name, "my_turn", 76'(my_turn), 76'(m_e.turn));
         chk(m_e.name, "cur_idx", 76'(cur_idx), 76'(m_e.idx));
         chk(m_e.name, "trn_out", {trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, cfg_interrupt_n},
             exp_out(m_e.sel));
         chk(m_e.name, "busy_timeout", 76'(busy_timeout), 76'(m_e.bt));
         chk(m_e.name, "timeout_idx", 76'(timeout_idx), 76'(m_e.tidx));
         chk(m_e.name, "proto_err", 76'(proto_err), 76'(m_e.pe));
      end
   end

   // Apply inputs for the next edge and queue what the DUT must show after it.
   task automatic vec(input string name, input logic [2:0] en, input logic [2:0] drv,
                      input logic [2:0] turn, input logic [1:0] idx, input int sel);
      exp_t e;
      reset             = g_rst;
      eng_enable        = en;
      driving_interface = drv;
      e.cyc  = cyc + 1;
      e.name = name;
      e.turn = turn;
      e.idx  = idx;
      e.sel  = sel;
      e.bt   = g_bt;
      e.tidx = g_tidx;
      e.pe   = g_pe;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic rot(input string name, input int i);
      for (int k = 0; k < 4; k++) vec(name, 3'b111, 3'b000, 3'b001 << i, 2'(i), i);
      vec({name, "_guard"}, 3'b111, 3'b000, 3'b000, 2'(i), i);
      vec({name, "_idle"}, 3'b111, 3'b000, 3'b000, 2'((i + 1) % 3), -1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $fatal(1, "bench timeout");
   end

   initial begin
      eng_trn_td          = {64'hA5A5_5A5A_DEAD_BEEF, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
      eng_trn_trem_n      = {8'h22, 8'h11, 8'h00};
      eng_trn_tsof_n      = 3'b010;
      eng_trn_teof_n      = 3'b001;
      eng_trn_tsrc_rdy_n  = 3'b100;
      eng_cfg_interrupt_n = 3'b011;
      g_rst = 1'b1; g_bt = 1'b0; g_tidx = 2'd0; g_pe = 1'b0;

      vec("reset", 3'b111, 3'b000, 3'b000, 2'd0, -1);
      vec("reset", 3'b111, 3'b000, 3'b000, 2'd0, -1);
      g_rst = 1'b0;

      rot("rr0", 0);
      rot("rr1", 1);
      rot("rr2", 2);
      rot("rr0b", 0);

      // Engine 1 drives from its 2nd grant cycle for 10 cycles
      vec("d1_g1", 3'b111, 3'b000, 3'b010, 2'd1, 1);
      vec("d1_g2", 3'b111, 3'b000, 3'b010, 2'd1, 1);
      for (int k = 0; k < 10; k++) vec("d1_busy", 3'b111, 3'b010, 3'b000, 2'd1, 1);
      vec("d1_drop", 3'b111, 3'b000, 3'b000, 2'd2, -1);
      for (int k = 0; k < 4; k++) vec("d1_next", 3'b111, 3'b000, 3'b100, 2'd2, 2);
      vec("d1_guard", 3'b111, 3'b000, 3'b000, 2'd2, 2);
      vec("d1_idle", 3'b111, 3'b000, 3'b000, 2'd0, -1);

      // Engine 0 drives in its guard cycle
      for (int k = 0; k < 4; k++) vec("g0_grant", 3'b111, 3'b000, 3'b001, 2'd0, 0);
      vec("g0_guard", 3'b111, 3'b000, 3'b000, 2'd0, 0);
      vec("g0_busy", 3'b111, 3'b001, 3'b000, 2'd0, 0);
      vec("g0_drop", 3'b111, 3'b000, 3'b000, 2'd1, -1);

      // Only engine 2 enabled, then nothing enabled
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++) vec("en100", 3'b100, 3'b000, 3'b100, 2'd2, 2);
         vec("en100_guard", 3'b100, 3'b000, 3'b000, 2'd2, 2);
         vec("en100_idle", 3'b100, 3'b000, 3'b000, 2'd0, -1);
      end
      for (int k = 0; k < 3; k++) vec("en000", 3'b000, 3'b000, 3'b000, 2'd0, -1);

      // Enable of the granted engine drops mid-window
      vec("edrop_g1", 3'b111, 3'b000, 3'b001, 2'd0, 0);
      vec("edrop_g2", 3'b111, 3'b000, 3'b001, 2'd0, 0);
      vec("edrop_guard", 3'b110, 3'b000, 3'b000, 2'd0, 0);
      vec("edrop_idle", 3'b110, 3'b000, 3'b000, 2'd1, -1);
      vec("edrop_g1b", 3'b110, 3'b000, 3'b010, 2'd1, 1);
      for (int k = 0; k < 3; k++) vec("edrop_grant", 3'b111, 3'b000, 3'b010, 2'd1, 1);
      vec("edrop_guard2", 3'b111, 3'b000, 3'b000, 2'd1, 1);
      vec("edrop_idle2", 3'b111, 3'b000, 3'b000, 2'd2, -1);

      // Engine 2 holds the interface 20 cycles: watchdog at busy count 16, enables ignored
      vec("wd_g1", 3'b111, 3'b000, 3'b100, 2'd2, 2);
      for (int k = 1; k <= 20; k++) begin
         if (k == 17) begin g_bt = 1'b1; g_tidx = 2'd2; end
         vec("wd_busy", (k >= 5) ? 3'b000 : 3'b111, 3'b100, 3'b000, 2'd2, 2);
      end
      vec("wd_drop", 3'b111, 3'b000, 3'b000, 2'd0, -1);
      vec("wd_next", 3'b111, 3'b000, 3'b001, 2'd0, 0);

      // Engine 2 drives while engine 0 holds the turn
      g_pe = 1'b1;
      vec("pe_foreign", 3'b111, 3'b100, 3'b001, 2'd0, 0);
      vec("pe_foreign", 3'b111, 3'b100, 3'b001, 2'd0, 0);
      vec("pe_g4", 3'b111, 3'b000, 3'b001, 2'd0, 0);
      vec("pe_guard", 3'b111, 3'b000, 3'b000, 2'd0, 0);
      vec("pe_idle", 3'b111, 3'b000, 3'b000, 2'd1, -1);

      // Drive arrives on the window's last cycle, then reset lands mid-BUSY
      for (int k = 0; k < 4; k++) vec("win_grant", 3'b111, 3'b000, 3'b010, 2'd1, 1);
      vec("win_busy", 3'b111, 3'b010, 3'b000, 2'd1, 1);
      vec("win_busy", 3'b111, 3'b010, 3'b000, 2'd1, 1);
      g_rst = 1'b1; g_bt = 1'b0; g_tidx = 2'd0; g_pe = 1'b0;
      vec("rst_busy", 3'b111, 3'b010, 3'b000, 2'd0, -1);
      g_rst = 1'b0;
      vec("post_rst", 3'b000, 3'b000, 3'b000, 2'd0, -1);
      vec("post_rst", 3'b000, 3'b000, 3'b000, 2'd0, -1);

      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain cyc=%0d got=%0d pending want=0", cyc, sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
